hash_bits_off_counter: RTL and testbench
========================================

// Module: hash_bits_off_counter
// PURPOSE
//  Parametrised Hamming-distance engine for the Skein search core.
//  - Accepts the XOR of candidate hash and target hash in CHUNK_W-bit chunks, one chunk per cycle.
//  - Population-counts each chunk and accumulates the counts over one full HASH_BITS hash.
//  - Emits the final bits-off score and tracks the best (minimum) score seen.
//  - Sits between the Skein output serializer and the result reporter; replaces the 1-bit-per-cycle counter.
// PARAMETERS
//  HASH_BITS  1024                     bits per hash; must be a multiple of CHUNK_W
//  CHUNK_W    64                       XOR bits consumed per accepted chunk; power of two, 1..HASH_BITS
//  COUNT_W    $clog2(HASH_BITS+1)      score width (11 for 1024); holds the value HASH_BITS exactly
//  NUM_CHUNKS HASH_BITS/CHUNK_W        localparam; chunks per hash
// PORTS
//  clk_i             in   1        clock
//  reset_i           in   1        asynchronous, active-high reset
//  start_i           in   1        pulse: begin a new hash, clear accumulator and chunk index
//  chunk_valid_i     in   1        chunk_i valid this cycle
//  chunk_i           in   CHUNK_W  hash XOR target bits, chunk 0 first
//  clear_best_i      in   1        pulse: set best_count_o to all-ones
//  busy_o            out  1        high in ACCUM or DRAIN
//  result_valid_o    out  1        1-cycle pulse: result_count_o updated
//  result_count_o    out  COUNT_W  bits-off score of the last completed hash; held until next result
//  new_best_o        out  1        1-cycle pulse with result_valid_o when result < previous best
//  best_count_o      out  COUNT_W  minimum score since reset/clear_best_i
//  protocol_err_o    out  1        1-cycle pulse: chunk_valid_i seen while not in ACCUM (chunk dropped)
// BEHAVIOUR
//  - Reset values: all state and outputs 0, except best_count_o = all-ones. FSM resets to IDLE.
//  - FSM states:
//    - IDLE: start_i -> ACCUM.
//    - ACCUM: a chunk is accepted when chunk_valid_i=1; chunk index increments.
//      Accepting chunk NUM_CHUNKS-1 -> DRAIN.
//    - DRAIN: wait for the pipeline to empty; final accumulate -> IDLE.
//  - Pipeline:
//    - Stage 1 registers popcount(chunk_i), CHUNK_W -> $clog2(CHUNK_W+1) bits, plus a last flag.
//    - Stage 2 adds the stage-1 count into the COUNT_W accumulator.
//    - Final sum cannot overflow because HASH_BITS fits in COUNT_W.
//  - Latency: result_valid_o is high in the 2nd cycle after the edge that accepts the last chunk.
//    result_count_o, best_count_o and new_best_o update on the same edge.
//  - Chunk timing: gaps (chunk_valid_i=0) in ACCUM are allowed; nothing is accumulated that cycle.
//    Back-to-back hashes need a start_i after busy_o drops.
//  - Best tracking: update best_count_o only on strict less-than. A tie gives no update and no new_best_o.
//  - clear_best_i and result_valid_o in the same cycle: clear wins. best = all-ones, new_best_o = 0.
//  - start_i in ACCUM/DRAIN aborts the hash:
//    - accumulator, chunk index and the stage-1 valid are cleared;
//    - no result is produced for the aborted hash;
//    - state -> ACCUM;
//    - a chunk_valid_i in the same cycle as start_i is accepted as chunk 0 of the new hash.
//  - start_i in IDLE with chunk_valid_i high: that chunk is accepted as chunk 0.
//  - chunk_valid_i in IDLE without start_i, or in DRAIN: chunk dropped, protocol_err_o pulses, state unchanged.
//  - CHUNK_W == HASH_BITS: NUM_CHUNKS = 1, so ACCUM -> DRAIN on the first accepted chunk.
//  - Asynchronous reset mid-operation: immediate return to reset values. No result pulse.
// STRUCTURE
//  - Shared package hash_pkg:
//    - HASH_BITS default;
//    - the clog2-based COUNT_W function;
//    - FSM state typedef/encoding {IDLE, ACCUM, DRAIN}.
//  - One sub-module: popcount_tree (parameter W). Purely combinational balanced adder tree,
//    output $clog2(W+1) bits. Instantiated once; stage-1 register lives in this block.
//  - Chunk index width: $clog2(NUM_CHUNKS), minimum 1.
// TESTING  (defaults HASH_BITS=1024, CHUNK_W=64)
//  1. Reset, start, 16 chunks of all-zeros -> result_count_o=0, new_best_o=1, best_count_o=0, busy_o low after DRAIN.
//  2. start, 16 chunks of all-ones (gaps inserted) -> result_count_o=1024; result_valid_o exactly 2 cycles after the 16th chunk; best unchanged.
//  3. Hash A with one bit set per chunk (score 16), then hash B with score 16 -> first gives new_best_o=1, best=16; second gives new_best_o=0 (tie).
//  4. start, 8 chunks of all-ones, start again, 16 zero chunks -> single result with result_count_o=0; no result for the aborted hash.
//  5. chunk_valid_i in IDLE -> protocol_err_o pulse, no accumulator change; clear_best_i with result_valid_o -> best_count_o=2047.
//  6. reset_i asserted asynchronously mid-ACCUM, between clock edges -> outputs at reset values immediately; next start/16 chunks of 0x1 gives result 16.

Source files
------------

// File: rtl/hash_bits_off_counter_pkg.sv
// Shared types and sizing helpers for the Skein
// bits-off scoring engine.
package hash_pkg;

  localparam int HASH_BITS_DEF = 1024;

  function automatic int count_w(input int bits);
    return $clog2(bits + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_e;

endpackage

// File: rtl/hash_bits_off_counter_if.sv
// Chunk input and score output bundle between the
// Skein serializer, the counter and the reporter.
interface hash_bits_off_counter_if #(
  parameter int CHUNK_W = 64,
  parameter int COUNT_W = 11
);
  logic               start_i;
  logic               chunk_valid_i;
  logic [CHUNK_W-1:0] chunk_i;
  logic               clear_best_i;
  logic               busy_o;
  logic               result_valid_o;
  logic [COUNT_W-1:0] result_count_o;
  logic               new_best_o;
  logic [COUNT_W-1:0] best_count_o;
  logic               protocol_err_o;

  modport master (
    output start_i, chunk_valid_i, chunk_i,
    output clear_best_i,
    input  busy_o, result_valid_o,
    input  result_count_o, new_best_o,
    input  best_count_o, protocol_err_o
  );

  modport slave (
    input  start_i, chunk_valid_i, chunk_i,
    input  clear_best_i,
    output busy_o, result_valid_o,
    output result_count_o, new_best_o,
    output best_count_o, protocol_err_o
  );
endinterface

// File: rtl/hash_bits_off_counter_popcount_tree.sv
// Combinational balanced adder tree counting the
// set bits of a power-of-two wide vector.
module popcount_tree #(
  parameter int W  = 64,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  output logic [OW-1:0] cnt
);
  generate
    if (W == 1) begin : g_leaf
      assign cnt = OW'(x);
    end else begin : g_node
      localparam int H  = W / 2;
      localparam int HW = $clog2(H + 1);
      logic [HW-1:0] lo_cnt;
      logic [HW-1:0] hi_cnt;

      popcount_tree #(.W(H), .OW(HW)) u_lo (
        .x  (x[H-1:0]),
        .cnt(lo_cnt)
      );
      popcount_tree #(.W(H), .OW(HW)) u_hi (
        .x  (x[W-1:H]),
        .cnt(hi_cnt)
      );

      assign cnt = OW'(lo_cnt) + OW'(hi_cnt);
    end
  endgenerate
endmodule

// File: rtl/hash_bits_off_counter.sv
// Two-stage Hamming-distance engine: popcount per chunk,
// then accumulate over one hash and track the best score.
module hash_bits_off_counter
  import hash_pkg::*;
#(
  parameter int HASH_BITS = HASH_BITS_DEF,
  parameter int CHUNK_W   = 64,
  parameter int COUNT_W   = count_w(HASH_BITS)
) (
  input logic clk_i,
  input logic reset_i,
  hash_bits_off_counter_if.slave bus
);
  localparam int NUM_CHUNKS = HASH_BITS / CHUNK_W;
  localparam int IDX_W =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PC_W = $clog2(CHUNK_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_CHUNKS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               accept, is_last, err;
  logic [PC_W-1:0]    pc, s1_cnt_q;
  logic               s1_valid_q, s1_last_q;
  logic [COUNT_W-1:0] acc_q, sum, best_q, res_q;
  logic               final_acc;
  logic               rv_q, nb_q, err_q;

  popcount_tree #(.W(CHUNK_W), .OW(PC_W)) u_pc (
    .x  (bus.chunk_i),
    .cnt(pc)
  );

  // start_i restarts the chunk index, so it also decides
  // which index the accepted chunk occupies.
  assign accept = bus.chunk_valid_i &&
                  (bus.start_i || state_q == ACCUM);
  assign is_last = bus.start_i ? (LAST_IDX == '0)
                               : (idx_q == LAST_IDX);
  assign err = bus.chunk_valid_i && !accept;
  assign sum = acc_q + COUNT_W'(s1_cnt_q);
  assign final_acc = s1_valid_q && s1_last_q &&
                     !bus.start_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DRAIN:   if (final_acc) state_d = IDLE;
      default: ;
    endcase
    if (bus.start_i) state_d = ACCUM;
    if (accept && is_last) state_d = DRAIN;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      if (accept) begin
        idx_q     <= (bus.start_i ? '0 : idx_q)
                     + IDX_W'(1);
        s1_cnt_q  <= pc;
        s1_last_q <= is_last;
      end else if (bus.start_i) begin
        idx_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      res_q  <= '0;
      best_q <= '1;
      rv_q   <= 1'b0;
      nb_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rv_q  <= 1'b0;
      nb_q  <= 1'b0;
      err_q <= err;
      if (bus.start_i) acc_q <= '0;
      else if (s1_valid_q) acc_q <= sum;
      if (final_acc) begin
        rv_q  <= 1'b1;
        res_q <= sum;
      end
      // A clear in the result cycle beats the compare.
      if (bus.clear_best_i) begin
        best_q <= '1;
      end else if (final_acc && sum < best_q) begin
        best_q <= sum;
        nb_q   <= 1'b1;
      end
    end
  end

  assign bus.busy_o         = (state_q != IDLE);
  assign bus.result_valid_o = rv_q;
  assign bus.result_count_o = res_q;
  assign bus.new_best_o     = nb_q;
  assign bus.best_count_o   = best_q;
  assign bus.protocol_err_o = err_q;
endmodule

// File: tb/tb_hash_bits_off_counter.sv
// Directed bench for hash_bits_off_counter with a
// transaction-level scoring model checked every cycle.
module tb_hash_bits_off_counter;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   rv_seen = 0;

  hash_bits_off_counter_if #(.CHUNK_W(64), .COUNT_W(11)) bus ();

  hash_bits_off_counter #(
    .HASH_BITS(1024), .CHUNK_W(64)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               nm, got, exp, $time);
    end
  endtask

  // Model: counts chunks and set bits per hash in
  // plain integers; result appears one edge after the
  // edge that accepts the final chunk.
  bit m_coll = 0;
  bit m_pend = 0;
  int m_cnt = 0;
  int m_sum = 0;
  int m_pval = 0;
  bit e_rv = 0, e_nb = 0, e_err = 0, e_busy = 0;
  int e_rc = 0;
  int e_best = 2047;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_coll = 0; m_pend = 0; m_cnt = 0; m_sum = 0;
      e_rv = 0; e_nb = 0; e_err = 0; e_busy = 0;
      e_rc = 0; e_best = 2047;
    end else begin
      e_rv = 0; e_nb = 0;
      e_err = bus.chunk_valid_i && !bus.start_i && !m_coll;
      if (bus.start_i) begin
        m_pend = 0; m_coll = 1; m_cnt = 0; m_sum = 0;
      end else if (m_pend) begin
        m_pend = 0;
        e_rv = 1;
        e_rc = m_pval;
        if (!bus.clear_best_i && m_pval < e_best) begin
          e_best = m_pval;
          e_nb = 1;
        end
      end
      if (bus.clear_best_i) e_best = 2047;
      if (bus.chunk_valid_i && m_coll) begin
        m_sum += $countones(bus.chunk_i);
        m_cnt++;
        if (m_cnt == N) begin
          m_coll = 0;
          m_pend = 1;
          m_pval = m_sum;
        end
      end
      e_busy = m_coll || m_pend;
    end
    #2;
    chk("busy", 32'(bus.busy_o), 32'(e_busy));
    chk("result_valid", 32'(bus.result_valid_o), 32'(e_rv));
    chk("result_count", 32'(bus.result_count_o), e_rc);
    chk("new_best", 32'(bus.new_best_o), 32'(e_nb));
    chk("best_count", 32'(bus.best_count_o), e_best);
    chk("protocol_err", 32'(bus.protocol_err_o), 32'(e_err));
  end

  always @(posedge clk) begin
    #3;
    if (bus.result_valid_o === 1'b1) rv_seen++;
  end

  function automatic logic [63:0] mk(input int kind,
                                     input int i);
    logic [63:0] one;
    one = 64'd1;
    case (kind)
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return one << i;
      3:       return one << ((i * 5 + 3) % 64);
      4:       return one;
      default: return 64'd0;
    endcase
  endfunction

  task automatic cyc(input bit s, input bit v,
                     input logic [63:0] c,
                     input bit clr);
    bus.start_i       = s;
    bus.chunk_valid_i = v;
    bus.chunk_i       = c;
    bus.clear_best_i  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic hash(input int kind, input int n,
                      input bit gaps, input bit sw);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) cyc(0, 0, '0, 0);
      cyc(sw && i == 0, 1, mk(kind, i), 0);
    end
  endtask

  initial begin
    bus.start_i       = 0;
    bus.chunk_valid_i = 0;
    bus.chunk_i       = '0;
    bus.clear_best_i  = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_best", 32'(bus.best_count_o), 2047);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_count", 32'(bus.result_count_o), 0);

    // all-zero hash
    cyc(1, 0, '0, 0);
    hash(0, N, 0, 0);
    chk("t1_no_rv_yet", 32'(bus.result_valid_o), 0);
    chk("t1_busy", 32'(bus.busy_o), 1);
    cyc(0, 0, '0, 0);
    chk("t1_rv", 32'(bus.result_valid_o), 1);
    chk("t1_count", 32'(bus.result_count_o), 0);
    chk("t1_new_best", 32'(bus.new_best_o), 1);
    chk("t1_best", 32'(bus.best_count_o), 0);
    chk("t1_idle", 32'(bus.busy_o), 0);

    // all-ones with gaps; chunk during DRAIN dropped
    cyc(1, 0, '0, 0);
    hash(1, N, 1, 0);
    chk("t2_lat1", 32'(bus.result_valid_o), 0);
    cyc(0, 1, mk(1, 0), 0);
    chk("t2_rv", 32'(bus.result_valid_o), 1);
    chk("t2_count", 32'(bus.result_count_o), 1024);
    chk("t2_best", 32'(bus.best_count_o), 0);
    chk("t2_drain_err", 32'(bus.protocol_err_o), 1);
    cyc(0, 0, '0, 0);

    // score 16 twice: second is a tie
    cyc(0, 0, '0, 1);
    chk("t3_clear", 32'(bus.best_count_o), 2047);
    cyc(1, 0, '0, 0);
    hash(2, N, 0, 0);
    cyc(0, 0, '0, 0);
    chk("t3a_count", 32'(bus.result_count_o), 16);
    chk("t3a_new_best", 32'(bus.new_best_o), 1);
    chk("t3a_best", 32'(bus.best_count_o), 16);
    cyc(1, 0, '0, 0);
    hash(3, N, 0, 0);
    cyc(0, 0, '0, 0);
    chk("t3b_rv", 32'(bus.result_valid_o), 1);
    chk("t3b_count", 32'(bus.result_count_o), 16);
    chk("t3b_tie", 32'(bus.new_best_o), 0);
    chk("t3b_best", 32'(bus.best_count_o), 16);

    // abort after 8 ones, restart with chunk 0 on start
    cyc(0, 0, '0, 0);
    rv_seen = 0;
    cyc(1, 0, '0, 0);
    hash(1, 8, 0, 0);
    hash(0, N, 0, 1);
    cyc(0, 0, '0, 0);
    chk("t4_count", 32'(bus.result_count_o), 0);
    chk("t4_new_best", 32'(bus.new_best_o), 1);
    chk("t4_best", 32'(bus.best_count_o), 0);
    repeat (3) cyc(0, 0, '0, 0);
    chk("t4_one_result", 32'(rv_seen), 1);

    // chunk in IDLE; clear coincident with result
    cyc(0, 1, mk(1, 0), 0);
    chk("t5_err", 32'(bus.protocol_err_o), 1);
    chk("t5_idle", 32'(bus.busy_o), 0);
    cyc(0, 0, '0, 1);
    chk("t5_err_pulse", 32'(bus.protocol_err_o), 0);
    cyc(1, 0, '0, 0);
    hash(4, N, 0, 0);
    cyc(0, 0, '0, 1);
    chk("t5_rv", 32'(bus.result_valid_o), 1);
    chk("t5_count", 32'(bus.result_count_o), 16);
    chk("t5_clear_nb", 32'(bus.new_best_o), 0);
    chk("t5_clear_best", 32'(bus.best_count_o), 2047);

    // asynchronous reset mid-ACCUM
    cyc(1, 0, '0, 0);
    hash(1, 5, 0, 0);
    bus.chunk_valid_i = 0;
    #3 rst = 1;
    #1;
    chk("t6_rst_busy", 32'(bus.busy_o), 0);
    chk("t6_rst_best", 32'(bus.best_count_o), 2047);
    chk("t6_rst_count", 32'(bus.result_count_o), 0);
    chk("t6_rst_rv", 32'(bus.result_valid_o), 0);
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 0, '0, 0);
    hash(4, N, 0, 0);
    cyc(0, 0, '0, 0);
    chk("t6_rv", 32'(bus.result_valid_o), 1);
    chk("t6_count", 32'(bus.result_count_o), 16);
    chk("t6_new_best", 32'(bus.new_best_o), 1);
    chk("t6_best", 32'(bus.best_count_o), 16);
    repeat (2) cyc(0, 0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
